hdpldadapt_hip_async_capture_array: RTL and testbench
=====================================================

Name: hdpldadapt_hip_async_capture_array

Overview:
- Parametrised successor of the HIP-to-AIB async capture stage in the TX channel. Synchronises FSR_WIDTH fast and SSR_WIDTH slow shift-register inputs into the async osc-clock domain.
- Presents each bit as a held snapshot that updates only on the shift-register load pulses.
- Adds per-group stability qualification with a pending capture, plus optional per-group change flags.
- Sits between the PLD_IF HIP sideband and the SR serialiser.

Parameters:
- FSR_WIDTH, 4, number of fast-SR bits.
- SSR_WIDTH, 40, number of slow-SR bits. Must be a multiple of SSR_GROUP.
- SSR_GROUP, 8, bits per slow-SR group; NGRP = SSR_WIDTH/SSR_GROUP.
- SYNC_STAGE, 4, synchroniser depth (2..6).
- STABLE_CYCLES, 2, consecutive unchanged synchronised cycles before a group is stable (1..15).
- FSR_RST_VAL, {FSR_WIDTH{1'b0}}, per-bit reset value of the fast path (sync chain and output).
- SSR_RST_VAL, {SSR_WIDTH{1'b1}}, per-bit reset value of the slow path.

Ports:
- tx_clock_async_tx_osc_clk  in  1  async osc clock; the only clock.
- tx_reset_async_tx_osc_clk_rst_n  in  1  asynchronous, active-low reset.
- hip_aib_fsr_in  in  FSR_WIDTH  asynchronous fast-SR data.
- hip_aib_ssr_in  in  SSR_WIDTH  asynchronous slow-SR data.
- tx_async_fabric_hssi_fsr_load  in  1  single-cycle fast-SR load pulse.
- tx_async_fabric_hssi_ssr_load  in  1  single-cycle slow-SR load pulse.
- r_ssr_polling_bypass  in  NGRP  per group: 1 = capture unconditionally, 0 = stability-qualified.
- hip_aib_async_fsr_in  out  FSR_WIDTH  fast snapshot.
- hip_aib_async_ssr_in  out  SSR_WIDTH  slow snapshot.
- ssr_capt_pending  out  NGRP  group has a load pending, awaiting stability.
- ssr_chg  out  NGRP  change flag; present only with the optional feature.

Behaviour:
- Reset (async assert, sync release):
  - sync chains and outputs load FSR_RST_VAL / SSR_RST_VAL;
  - stability counters 0; pending 0; ssr_chg 0.
- Sync: every bit passes through a SYNC_STAGE-flop chain. Input-to-sync latency is SYNC_STAGE cycles.
- Fast path: on an fsr_load cycle, the fsr output register takes the sync value at the next edge (1-cycle latency). Otherwise it holds. No qualification is applied.
- Slow path, stability counter per group:
  - clears to 0 when the synchronised group value differs from its previous-cycle value;
  - otherwise increments, saturating at STABLE_CYCLES;
  - stable = (count == STABLE_CYCLES).
- Slow path, bypass=1: capture on the edge after an ssr_load cycle; pending stays 0.
- Slow path, bypass=0, per-group states IDLE / PEND:
  - IDLE & load & stable -> capture, stay IDLE.
  - IDLE & load & !stable -> PEND, pending=1.
  - PEND & stable -> capture on that edge, go IDLE.
  - PEND & load -> stay PEND. Loads merge and are not queued.
  - PEND & bypass switched to 1 -> capture on next edge, go IDLE.
- Load and data change on the same cycle: the counter clears that cycle, so the group is not stable and goes to PEND.
- STABLE_CYCLES=1: capture needs one unchanged cycle.
- Reset mid-PEND: pending is dropped, and outputs return to their reset values.
- Groups are independent. Captures of one group never gate another.

Optional Feature:
- Macro: HDPLDADAPT_ASYNC_CAPT_CHG_EN.
- Defined:
  - ssr_chg[g] sets on a capture whose new group value differs from the held value;
  - it clears on the next ssr_load cycle, and set wins if set and clear coincide;
  - it resets to 0.
- Undefined: the ssr_chg port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package hdpldadapt_async_capt_pkg holds:
  - the state encoding type (IDLE=1'b0, PEND=1'b1);
  - the counter width function clog2(STABLE_CYCLES+1);
  - the default reset-value constants.
- Sub-module hdpldadapt_async_capt_group (one slow group):
  - contents: sync chain, counter, FSM, output register, change flag;
  - instanced NGRP times by generate.
  - The fast path uses the same module with SSR_GROUP=1, bypass tied to 1, and FSR_RST_VAL bits.

Test Plan:
- Reset: hold rst_n=0 and drive all inputs 1 -> fsr_out=4'h0, ssr_out=40'hFF_FFFF_FFFF, pending=0. After release and SYNC_STAGE+1 cycles with no load, outputs are unchanged.
- Fast load: fsr_in=4'hA, wait 6 cycles, pulse fsr_load -> fsr_out=4'hA exactly one edge after the pulse. fsr_in=4'h5 with no load -> fsr_out holds 4'hA.
- Polling qualified: group0 bypass=0; ssr_in[7:0] toggles 8'h3C/8'hC3 each cycle; pulse ssr_load -> pending[0]=1, out holds 8'hFF. Freeze at 8'h3C -> out=8'h3C, pending=0 at SYNC_STAGE+STABLE_CYCLES edges after the freeze.
- Bypass: group1 bypass=1 with a toggling input; pulse ssr_load -> out[15:8] equals the sync value on the next edge; pending[1]=0 throughout.
- Merged loads and reset: group2 in PEND; three more ssr_loads -> one capture when stable. Assert rst_n during PEND -> pending=0 and out[23:16]=8'hFF immediately (async).
- Change flag (macro on): capture 8'h12 then 8'h12 -> ssr_chg[3]=0. Capture 8'h34 -> chg=1; next load with an unchanged value -> chg=0.

Source files
------------

// File: rtl/hdpldadapt_async_capt_pkg.sv
// Shared types and helpers for the HIP-to-AIB async capture array.
// Holds the per-group state encoding, counter sizing and reset defaults.
package hdpldadapt_async_capt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } capt_state_e;

    localparam logic DEF_FSR_RST_BIT = 1'b0;
    localparam logic DEF_SSR_RST_BIT = 1'b1;

    // Width needed to hold 0..stable_cycles
    function automatic int cnt_w(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/hdpldadapt_async_capt_group.sv
// One capture group: sync chain, stability counter, IDLE/PEND FSM,
// held snapshot register and (with HDPLDADAPT_ASYNC_CAPT_CHG_EN) change flag.
module hdpldadapt_async_capt_group
    import hdpldadapt_async_capt_pkg::*;
#(
    parameter int         W             = 8,
    parameter int         SYNC_STAGE    = 4,
    parameter int         STABLE_CYCLES = 2,
    parameter logic [W-1:0] RST_VAL     = {W{1'b1}}
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_load,
    input  logic         i_bypass,
    output logic [W-1:0] o_data,
    output logic         o_pending
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
    ,
    output logic         o_chg
`endif
);

    localparam int CW = cnt_w(STABLE_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [W-1:0]  r_sync [SYNC_STAGE];
    logic [W-1:0]  r_prev;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;
    capt_state_e   r_state;

    logic [W-1:0]  w_sync;
    logic          w_changed;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_stable;
    capt_state_e   w_state_nxt;
    logic          w_capture;

    assign w_sync    = r_sync[SYNC_STAGE-1];
    assign w_changed = (w_sync != r_prev);

    // Synchroniser chain into the osc-clock domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGE; i++) begin
                r_sync[i] <= RST_VAL;
            end
        end else begin
            r_sync[0] <= i_data;
            for (int i = 1; i < SYNC_STAGE; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Previous-cycle synchronised value, for change detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= w_sync;
        end
    end

    // A change clears the run length in the same cycle it is seen
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_changed) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != SAT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    assign w_stable = (w_cnt_nxt == SAT);

    // Saturating run-length counter of unchanged cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: park unstable loads, release on stability or bypass
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_load && !i_bypass && !w_stable) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (i_bypass || w_stable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FSM output: when to take the synchronised value
    always_comb begin
        w_capture = 1'b0;
        unique case (r_state)
            ST_IDLE: w_capture = i_load && (i_bypass || w_stable);
            ST_PEND: w_capture = i_bypass || w_stable;
        endcase
    end

    // Held snapshot, updated only on a capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= RST_VAL;
        end else if (w_capture) begin
            r_data <= w_sync;
        end
    end

    assign o_data    = r_data;
    assign o_pending = (r_state == ST_PEND);

`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
    logic r_chg;

    // Change flag: set on a differing capture, cleared by the next load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chg <= 1'b0;
        end else if (w_capture && (w_sync != r_data)) begin
            r_chg <= 1'b1;
        end else if (i_load) begin
            r_chg <= 1'b0;
        end
    end

    assign o_chg = r_chg;
`endif

endmodule

// File: rtl/hdpldadapt_hip_async_capture_array.sv
// HIP-to-AIB async capture array: fast and slow SR snapshots in the osc domain.
// Optional per-group change flags with HDPLDADAPT_ASYNC_CAPT_CHG_EN.
module hdpldadapt_hip_async_capture_array
    import hdpldadapt_async_capt_pkg::*;
#(
    parameter int FSR_WIDTH     = 4,
    parameter int SSR_WIDTH     = 40,
    parameter int SSR_GROUP     = 8,
    parameter int SYNC_STAGE    = 4,
    parameter int STABLE_CYCLES = 2,
    parameter logic [FSR_WIDTH-1:0] FSR_RST_VAL = {FSR_WIDTH{DEF_FSR_RST_BIT}},
    parameter logic [SSR_WIDTH-1:0] SSR_RST_VAL = {SSR_WIDTH{DEF_SSR_RST_BIT}},
    localparam int NGRP = SSR_WIDTH / SSR_GROUP
) (
    input  logic                 tx_clock_async_tx_osc_clk,
    input  logic                 tx_reset_async_tx_osc_clk_rst_n,
    input  logic [FSR_WIDTH-1:0] hip_aib_fsr_in,
    input  logic [SSR_WIDTH-1:0] hip_aib_ssr_in,
    input  logic                 tx_async_fabric_hssi_fsr_load,
    input  logic                 tx_async_fabric_hssi_ssr_load,
    input  logic [NGRP-1:0]      r_ssr_polling_bypass,
    output logic [FSR_WIDTH-1:0] hip_aib_async_fsr_in,
    output logic [SSR_WIDTH-1:0] hip_aib_async_ssr_in,
    output logic [NGRP-1:0]      ssr_capt_pending
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
    ,
    output logic [NGRP-1:0]      ssr_chg
`endif
);

    logic [FSR_WIDTH-1:0] w_fsr_pend_unused;
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
    logic [FSR_WIDTH-1:0] w_fsr_chg_unused;
`endif

    // Fast path: one bypassed single-bit group per bit
    for (genvar i = 0; i < FSR_WIDTH; i++) begin : g_fsr
        hdpldadapt_async_capt_group #(
            .W             (1),
            .SYNC_STAGE    (SYNC_STAGE),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RST_VAL       (FSR_RST_VAL[i])
        ) u_fsr (
            .i_clk     (tx_clock_async_tx_osc_clk),
            .i_rst_n   (tx_reset_async_tx_osc_clk_rst_n),
            .i_data    (hip_aib_fsr_in[i]),
            .i_load    (tx_async_fabric_hssi_fsr_load),
            .i_bypass  (1'b1),
            .o_data    (hip_aib_async_fsr_in[i]),
            .o_pending (w_fsr_pend_unused[i])
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
            ,
            .o_chg     (w_fsr_chg_unused[i])
`endif
        );
    end

    // Slow path: independent stability-qualified groups
    for (genvar g = 0; g < NGRP; g++) begin : g_ssr
        hdpldadapt_async_capt_group #(
            .W             (SSR_GROUP),
            .SYNC_STAGE    (SYNC_STAGE),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RST_VAL       (SSR_RST_VAL[g*SSR_GROUP +: SSR_GROUP])
        ) u_ssr (
            .i_clk     (tx_clock_async_tx_osc_clk),
            .i_rst_n   (tx_reset_async_tx_osc_clk_rst_n),
            .i_data    (hip_aib_ssr_in[g*SSR_GROUP +: SSR_GROUP]),
            .i_load    (tx_async_fabric_hssi_ssr_load),
            .i_bypass  (r_ssr_polling_bypass[g]),
            .o_data    (hip_aib_async_ssr_in[g*SSR_GROUP +: SSR_GROUP]),
            .o_pending (ssr_capt_pending[g])
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
            ,
            .o_chg     (ssr_chg[g])
`endif
        );
    end

endmodule

// File: tb/tb_hdpldadapt_hip_async_capture_array.sv
// Directed bench for hdpldadapt_hip_async_capture_array (default params).
// Change-flag checks are compiled when HDPLDADAPT_ASYNC_CAPT_CHG_EN is set.
module tb_hdpldadapt_hip_async_capture_array;

    localparam int NGRP = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fsr_in;
    logic [39:0] ssr_in;
    logic        fsr_ld;
    logic        ssr_ld;
    logic [4:0]  byp;
    logic [3:0]  fsr_out;
    logic [39:0] ssr_out;
    logic [4:0]  pend;
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
    logic [4:0]  chg;
`endif

    int n_chk = 0;
    int n_err = 0;

    hdpldadapt_hip_async_capture_array dut (
        .tx_clock_async_tx_osc_clk       (clk),
        .tx_reset_async_tx_osc_clk_rst_n (rst_n),
        .hip_aib_fsr_in                  (fsr_in),
        .hip_aib_ssr_in                  (ssr_in),
        .tx_async_fabric_hssi_fsr_load   (fsr_ld),
        .tx_async_fabric_hssi_ssr_load   (ssr_ld),
        .r_ssr_polling_bypass            (byp),
        .hip_aib_async_fsr_in            (fsr_out),
        .hip_aib_async_ssr_in            (ssr_out),
        .ssr_capt_pending                (pend)
`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
        ,
        .ssr_chg                         (chg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] fsr;
        logic       ld;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bv [16];
        logic [7:0] e1;

        // Fast path: load in record m captures the fsr of record m-4
        tbl[0]  = '{4'hA, 1'b0, 4'h0};
        tbl[1]  = '{4'hA, 1'b0, 4'h0};
        tbl[2]  = '{4'hA, 1'b0, 4'h0};
        tbl[3]  = '{4'hA, 1'b0, 4'h0};
        tbl[4]  = '{4'hA, 1'b0, 4'h0};
        tbl[5]  = '{4'hA, 1'b1, 4'hA};
        tbl[6]  = '{4'h5, 1'b0, 4'hA};
        tbl[7]  = '{4'h5, 1'b0, 4'hA};
        tbl[8]  = '{4'h5, 1'b0, 4'hA};
        tbl[9]  = '{4'h5, 1'b1, 4'hA};
        tbl[10] = '{4'h5, 1'b1, 4'h5};
        tbl[11] = '{4'h3, 1'b0, 4'h5};
        tbl[12] = '{4'h3, 1'b0, 4'h5};
        tbl[13] = '{4'h3, 1'b1, 4'h5};
        tbl[14] = '{4'h3, 1'b1, 4'h5};
        tbl[15] = '{4'h3, 1'b1, 4'h3};
        tbl[16] = '{4'h0, 1'b0, 4'h3};

        // Reset with every input driven high
        rst_n  = 1'b0;
        fsr_in = 4'hF;
        ssr_in = '1;
        fsr_ld = 1'b1;
        ssr_ld = 1'b1;
        byp    = '1;
        repeat (3) step();
        chk("rst_fsr", 64'(fsr_out), 64'h0);
        chk("rst_ssr", 64'(ssr_out), 64'hFF_FFFF_FFFF);
        chk("rst_pend", 64'(pend), 64'h0);

        fsr_ld = 1'b0;
        ssr_ld = 1'b0;
        byp    = 5'b00010;
        #2 rst_n = 1'b1;
        repeat (5) step();
        chk("post_rst_fsr", 64'(fsr_out), 64'h0);
        chk("post_rst_ssr", 64'(ssr_out), 64'hFF_FFFF_FFFF);
        chk("post_rst_pend", 64'(pend), 64'h0);

        // Fast path table
        for (int i = 0; i < 17; i++) begin
            fsr_in = tbl[i].fsr;
            fsr_ld = tbl[i].ld;
            step();
            chk($sformatf("fsr_vec%0d", i), 64'(fsr_out), 64'(tbl[i].exp));
        end
        fsr_ld = 1'b0;

        // Group 0 qualified: toggling input, load goes pending
        for (int k = 0; k < 8; k++) begin
            ssr_in[7:0] = k[0] ? 8'hC3 : 8'h3C;
            step();
        end
        ssr_in[7:0] = 8'h3C;
        ssr_ld = 1'b1;
        step();
        ssr_ld = 1'b0;
        chk("g0_pend_set", 64'(pend[0]), 64'h1);
        chk("g0_hold_ff", 64'(ssr_out[7:0]), 64'hFF);
        ssr_in[7:0] = 8'hC3;
        step();
        chk("g0_pend_k9", 64'(pend[0]), 64'h1);
        ssr_in[7:0] = 8'h3C;
        step();
        chk("g0_pend_k10", 64'(pend[0]), 64'h1);
        ssr_in[7:0] = 8'hC3;
        step();
        // Freeze edge F samples 3C; capture expected at F+6
        ssr_in[7:0] = 8'h3C;
        step();
        repeat (4) step();
        step();
        chk("g0_pend_f5", 64'(pend[0]), 64'h1);
        chk("g0_out_f5", 64'(ssr_out[7:0]), 64'hFF);
        step();
        chk("g0_pend_f6", 64'(pend[0]), 64'h0);
        chk("g0_out_f6", 64'(ssr_out[7:0]), 64'h3C);

        // Group 1 bypass: load at k captures input of record k-4
        e1 = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            bv[k] = k[0] ? 8'hF0 : 8'h0F;
            ssr_in[15:8] = bv[k];
            ssr_ld = (k == 9) || (k == 12);
            step();
            if (k == 9 || k == 12) e1 = bv[k-4];
            chk($sformatf("g1_out_k%0d", k), 64'(ssr_out[15:8]), 64'(e1));
            chk($sformatf("g1_pend_k%0d", k), 64'(pend[1]), 64'h0);
        end
        ssr_ld = 1'b0;
        chk("g0_kept_3c", 64'(ssr_out[7:0]), 64'h3C);

        // Group 2: pending, three merged loads, single capture
        for (int k = 0; k < 8; k++) begin
            ssr_in[23:16] = k[0] ? 8'hAA : 8'h55;
            step();
        end
        ssr_in[23:16] = 8'h55;
        ssr_ld = 1'b1;
        step();
        chk("g2_pend_set", 64'(pend[2]), 64'h1);
        for (int k = 9; k < 15; k++) begin
            ssr_in[23:16] = k[0] ? 8'hAA : 8'h55;
            ssr_ld = (k == 10) || (k == 12) || (k == 14);
            step();
            chk($sformatf("g2_pend_k%0d", k), 64'(pend[2]), 64'h1);
            chk($sformatf("g2_out_k%0d", k), 64'(ssr_out[23:16]), 64'hFF);
        end
        ssr_ld = 1'b0;
        ssr_in[23:16] = 8'hAA;
        step();
        repeat (4) step();
        step();
        chk("g2_pend_f5", 64'(pend[2]), 64'h1);
        step();
        chk("g2_pend_f6", 64'(pend[2]), 64'h0);
        chk("g2_out_f6", 64'(ssr_out[23:16]), 64'hAA);
        ssr_in[23:16] = 8'h5A;
        repeat (8) step();
        chk("g2_no_queue", 64'(ssr_out[23:16]), 64'hAA);
        chk("g2_idle", 64'(pend[2]), 64'h0);

        // Async reset while group 2 is pending
        for (int k = 0; k < 8; k++) begin
            ssr_in[23:16] = k[0] ? 8'hAA : 8'h55;
            step();
        end
        ssr_in[23:16] = 8'h55;
        ssr_ld = 1'b1;
        step();
        ssr_ld = 1'b0;
        chk("g2_pend_again", 64'(pend[2]), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pend", 64'(pend), 64'h0);
        chk("arst_g2", 64'(ssr_out[23:16]), 64'hFF);
        chk("arst_ssr", 64'(ssr_out), 64'hFF_FFFF_FFFF);
        chk("arst_fsr", 64'(fsr_out), 64'h0);
        step();
        #2 rst_n = 1'b1;
        ssr_in[23:16] = 8'hFF;

`ifdef HDPLDADAPT_ASYNC_CAPT_CHG_EN
        chk("chg_rst", 64'(chg), 64'h0);
        ssr_in[31:24] = 8'h12;
        repeat (8) step();
        ssr_ld = 1'b1;
        step();
        ssr_ld = 1'b0;
        chk("chg_cap12_out", 64'(ssr_out[31:24]), 64'h12);
        chk("chg_cap12_set", 64'(chg[3]), 64'h1);
        repeat (3) step();
        ssr_ld = 1'b1;
        step();
        ssr_ld = 1'b0;
        chk("chg_same12", 64'(chg[3]), 64'h0);
        ssr_in[31:24] = 8'h34;
        repeat (8) step();
        ssr_ld = 1'b1;
        step();
        ssr_ld = 1'b0;
        chk("chg_cap34_out", 64'(ssr_out[31:24]), 64'h34);
        chk("chg_cap34_set", 64'(chg[3]), 64'h1);
        repeat (3) step();
        ssr_ld = 1'b1;
        step();
        ssr_ld = 1'b0;
        chk("chg_clr", 64'(chg[3]), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
